// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// The PARITY state exists only when UART_LOADER_PARITY_EN is defined.
package uart_loader_pkg;

  localparam int unsigned IMEM_WORDS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_LOADER_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop rx synchronizer, receive FSM and bit timer.
// Adds an even-parity check when UART_LOADER_PARITY_EN is defined.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err,
  output logic       active_c
);

  localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned TW  = $clog2(CPB + 1);

  rx_state_t     state;
  logic [1:0]    sync;
  logic          rx_d;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rxs_c;
  logic          expired_c;
  logic          stop_ok_c;
`ifdef UART_LOADER_PARITY_EN
  logic          par_err;
`endif

  assign rxs_c     = sync[1];
  assign expired_c = (timer == TW'(1));
  assign active_c  = (state != ST_IDLE);
`ifdef UART_LOADER_PARITY_EN
  assign stop_ok_c = rxs_c && !par_err;
`else
  assign stop_ok_c = rxs_c;
`endif

  // Timer counts down to 1; the sample is taken on the cycle it reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      rx_d       <= 1'b1;
      state      <= ST_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_err   <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      sync       <= {sync[0], rx};
      rx_d       <= rxs_c;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_d && !rxs_c) begin
              state <= ST_START;
              timer <= TW'(CPB / 2);
            end
          end
          ST_START: begin
            if (expired_c) begin
              if (!rxs_c) begin
                state   <= ST_DATA;
                timer   <= TW'(CPB);
                bit_idx <= '0;
`ifdef UART_LOADER_PARITY_EN
                par_err <= 1'b0;
`endif
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          ST_DATA: begin
            if (expired_c) begin
              shreg <= {rxs_c, shreg[7:1]};
              timer <= TW'(CPB);
              if (bit_idx == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
`ifdef UART_LOADER_PARITY_EN
          ST_PARITY: begin
            if (expired_c) begin
              par_err <= (rxs_c != ^shreg);
              timer   <= TW'(CPB);
              state   <= ST_STOP;
            end else begin
              timer <= timer - TW'(1);
            end
          end
`endif
          ST_STOP: begin
            if (expired_c) begin
              state      <= ST_IDLE;
              byte_data  <= shreg;
              byte_valid <= stop_ok_c;
              byte_err   <= !stop_ok_c;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a UART program image into instruction memory as little-endian 32-bit words.
// Define UART_LOADER_PARITY_EN for 8E1 framing; default is 8N1.
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        prog,
  input  logic        rx,
  output logic        imem_en,
  output logic        imem_prog_ena,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_din,
  output logic [10:0] word_count,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(IMEM_WORDS);
  localparam int unsigned CW = AW + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       rx_active_c;
  logic       prog_d;
  logic [1:0] byte_idx;

  uart_rx_byte #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (Rst),
    .en        (prog),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err),
    .active_c  (rx_active_c)
  );

  assign busy = rx_active_c || (byte_idx != 2'd0);

  // Bytes land directly in imem_din so the word is complete in the strobe cycle.
  always_ff @(posedge clk) begin
    if (Rst) begin
      prog_d        <= 1'b0;
      byte_idx      <= '0;
      imem_en       <= 1'b0;
      imem_prog_ena <= 1'b0;
      imem_addr     <= '0;
      imem_din      <= '0;
      word_count    <= '0;
      frame_err     <= 1'b0;
    end else begin
      prog_d        <= prog;
      imem_en       <= 1'b0;
      imem_prog_ena <= 1'b0;
      if (!prog) begin
        byte_idx <= '0;
      end else if (!prog_d) begin
        imem_addr  <= '0;
        word_count <= '0;
        byte_idx   <= '0;
        frame_err  <= 1'b0;
      end else begin
        if (imem_prog_ena) begin
          imem_addr <= imem_addr + AW'(1);
          if (word_count != CW'(IMEM_WORDS))
            word_count <= word_count + CW'(1);
        end
        if (byte_err)
          frame_err <= 1'b1;
        if (byte_valid) begin
          imem_din[{byte_idx, 3'b000} +: 8] <= byte_data;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            imem_en       <= 1'b1;
            imem_prog_ena <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

- Receives a serial program image on `rx` while `prog` is high.
- Assembles received bytes little-endian into 32-bit words.
- Writes each completed word into instruction memory through the `imem_*` program port of the core/memory-controller bus, at sequential word addresses starting from 0.
- Sits upstream of the memory controller's imem program path; the top level wires its outputs to the bus signals `imem_en`, `imem_prog_ena`, `imem_addr` and `imem_din`.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000, input clock frequency.
- `BAUD`, default 115200, serial rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division, must be ≥ 4).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `Rst`  in  1  reset; synchronous, active-high.
- `prog`  in  1  load enable; level-sensitive.
- `rx`  in  1  UART receive pin; asynchronous; idle high.
- `imem_en`  out  1  imem enable; pulses with each write.
- `imem_prog_ena`  out  1  imem write strobe; one cycle per word.
- `imem_addr`  out  10  imem word address.
- `imem_din`  out  32  word being written.
- `word_count`  out  11  words written since the last `prog` rising edge.
- `frame_err`  out  1  sticky: a bad stop bit or a parity error has occurred.
- `busy`  out  1  high while a frame is being received or a partial word is held.

## Operation
- Reset values: every output is 0, the receive FSM is in IDLE, the byte index is 0, and the rx synchronizer flops are 1.
- Rx synchronization: `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Receive FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: a high-to-low transition on the synchronized rx moves to START and loads the bit timer with `CLKS_PER_BIT/2`.
  - START: when the timer expires, rx is resampled.
    - Still low: go to DATA; timer is reloaded with `CLKS_PER_BIT`.
    - High: treat as a glitch and return to IDLE with no error.
  - DATA: 8 samples, one per `CLKS_PER_BIT`, shifted in LSB first.
  - STOP: one sample.
    - High: byte is valid.
    - Low: set `frame_err` and discard the byte.
- Word assembly:
  - Byte k (k = 0..3) of a word goes to `imem_din[8k+7:8k]`.
  - On the 4th valid byte, `imem_en` and `imem_prog_ena` are high for exactly one cycle. During that cycle `imem_addr` is the current address and `imem_din` is the completed word.
  - In the following cycle the address increments and `word_count` increments; the byte index returns to 0.
- Address wrap: `imem_addr` wraps from 1023 to 0. `word_count` saturates at 1024 and does not wrap.
- `prog` low:
  - The FSM is forced to IDLE and any partial word is discarded.
  - `imem_en` and `imem_prog_ena` are held at 0.
  - `imem_addr`, `word_count` and `frame_err` hold their values.
- `prog` rising edge: `imem_addr`, `word_count`, the byte index and `frame_err` clear to 0 in that cycle.
- Reset mid-frame or mid-word: reset returns to the full reset state. No write strobe is issued in the reset cycle or the cycle after it.
- Simultaneous events: `prog` falling in the same cycle a word completes suppresses the write; `prog` has priority.
- `busy` = (FSM ≠ IDLE) or (byte index ≠ 0).

## Timing
- Pin to synchronized rx: 2 cycles.
- Start edge detected at cycle s. Start check at s + `CLKS_PER_BIT/2`. Data bit i is sampled at s + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`. Stop bit is sampled one bit period after the last data bit (after the parity bit when parity is enabled).
- Byte valid is registered 1 cycle after the stop sample.
- Write strobe is asserted in the cycle immediately after the 4th byte becomes valid.
- A new start edge is accepted in the cycle after the stop sample, so back-to-back frames with no idle gap are supported.

## Configuration
- `UART_LOADER_PARITY_EN` defined:
  - Each frame carries an even-parity bit after bit 7, and the FSM includes the PARITY state.
  - A parity mismatch sets `frame_err` and discards the byte; the STOP state is still traversed.
- `UART_LOADER_PARITY_EN` undefined: 8N1 framing; the PARITY state does not exist.

## Structure
- Package `uart_loader_pkg` holds:
  - the FSM state enum `rx_state_t`;
  - the constant function `clks_per_bit(CLK_HZ, BAUD)`;
  - the localparam `IMEM_WORDS = 1024`.
- Sub-module `uart_rx_byte` contains the synchronizer, the receive FSM and the bit timer. Its outputs are `byte_valid`, `byte_data[7:0]` and `byte_err`.
- The top level of this block handles word assembly, addressing and `prog` edge handling.

## Test plan
All scenarios use `CLK_HZ=1_000_000` and `BAUD=100_000`, giving 10 clocks per bit.
- Reset, then `prog`=1 and send bytes 0x13,0x05,0x10,0x00 → one strobe with `imem_addr`=0 and `imem_din`=0x00100513; then `word_count`=1 and `imem_addr`=1.
- Send 8 bytes back-to-back with no idle gap → two strobes at addresses 0 and 1; `busy` is low after the final stop bit.
- Send a frame with the stop bit low → `frame_err`=1, no byte counted, the next 4 good bytes still produce one write; a new `prog` rising edge clears `frame_err` to 0.
- Pulse rx low for 3 cycles → no byte received, `frame_err` stays 0, `busy` returns to 0.
- Send 2 bytes, drop `prog`, raise it again, send 4 bytes → exactly one write, at address 0, containing only the last 4 bytes.
- Preload 1023 words, then send one more word → write at `imem_addr`=1023, after which `imem_addr`=0 and `word_count`=1024. With `UART_LOADER_PARITY_EN` defined, a byte sent with odd parity sets `frame_err`.
